// File: rtl/readout_scheduler_if.sv
// Byte stream from the readout scheduler to the output pins.
// master drives the byte and its qualifiers, slave returns ready.
interface readout_scheduler_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       sof;
  logic       eof;

  modport master (output data, valid, sof, eof, input ready);
  modport slave  (input data, valid, sof, eof, output ready);
endinterface

// File: rtl/readout_scheduler.sv
// Readout scheduler: walks every row/column channel, selects each counter
// field on the external result mux, captures the word and streams a header
// byte plus MSB-first data bytes per channel. Single-shot or continuous.
module readout_scheduler #(
  parameter int PIXELS       = 128,
  parameter int COUNTER_BITS = 32,
  parameter int IDX_BITS     = 8,
  parameter int FCNT_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cont,
  output logic [IDX_BITS-1:0]     sel_idx,
  output logic [1:0]              sel_field,
  input  logic [COUNTER_BITS-1:0] data_in,
  readout_scheduler_if.master     out,
  output logic                    busy,
  output logic                    frame_done,
  output logic [FCNT_BITS-1:0]    frame_cnt
);

  localparam int NBYTES = COUNTER_BITS / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(2 * PIXELS - 1);
  localparam logic [BC_W-1:0]     LAST_BYTE = BC_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEL, CAP, SEND} state_t;

  state_t                  state;
  logic [IDX_BITS-1:0]     idx;
  logic [1:0]              field;
  logic [BC_W-1:0]         byte_cnt;
  logic [COUNTER_BITS-1:0] word;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_sof;
  logic                    out_eof;

  logic                    hs;
  logic                    last_ch;
  logic [COUNTER_BITS-1:0] word_nx;

  assign hs      = out_valid & out.ready;
  assign last_ch = (idx == LAST_IDX) && (field == 2'd2);
  // word is consumed by shifting left, so the next byte is always on top
  assign word_nx = word << 8;

  assign out.data  = out_data;
  assign out.valid = out_valid;
  assign out.sof   = out_sof;
  assign out.eof   = out_eof;

  // Frame sequencer; every output is registered here so valid never
  // depends combinationally on ready and stalled bytes hold by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      field      <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      sel_idx    <= '0;
      sel_field  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            field     <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= 8'h00;
            out_sof   <= 1'b1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            sel_idx   <= idx;
            sel_field <= field;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            state     <= SEL;
          end
        end
        // mux result settles one cycle after the select changes
        SEL: state <= CAP;
        CAP: begin
          word      <= data_in;
          byte_cnt  <= '0;
          out_data  <= data_in[COUNTER_BITS-1 -: 8];
          out_valid <= 1'b1;
          out_eof   <= last_ch && (LAST_BYTE == '0);
          state     <= SEND;
        end
        SEND: begin
          if (hs) begin
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= BC_W'(byte_cnt + 1'b1);
              word     <= word_nx;
              out_data <= word_nx[COUNTER_BITS-1 -: 8];
              out_eof  <= last_ch && (BC_W'(byte_cnt + 1'b1) == LAST_BYTE);
            end else begin
              out_eof <= 1'b0;
              if (field != 2'd2) begin
                field     <= field + 2'd1;
                sel_field <= field + 2'd1;
                out_valid <= 1'b0;
                state     <= SEL;
              end else if (idx != LAST_IDX) begin
                idx      <= idx + 1'b1;
                field    <= '0;
                out_data <= 8'(idx + 1'b1);
                out_sof  <= 1'b0;
                state    <= HDR;
              end else begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                idx        <= '0;
                field      <= '0;
                if (cont) begin
                  // back-to-back frame: header of channel 0 goes out next
                  out_data <= 8'h00;
                  out_sof  <= 1'b1;
                  state    <= HDR;
                end else begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler: PIXELS=2, 32-bit counters and a
// 2-bit frame counter so wrap-around shows up within a few frames.
module tb_readout_scheduler;
  localparam int P   = 2;
  localparam int CB  = 32;
  localparam int NB  = CB / 8;
  localparam int CHB = 1 + 3 * NB;     // bytes per channel
  localparam int FB  = 2 * P * CHB;    // bytes per frame (52)
  localparam int FCB = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           cont = 1'b0;
  logic           dead = 1'b0;
  logic [7:0]     sel_idx;
  logic [1:0]     sel_field;
  logic [CB-1:0]  data_in = '0;
  logic           busy;
  logic           frame_done;
  logic [FCB-1:0] frame_cnt;
  logic [FCB-1:0] exp_fcnt = '0;
  int             n_chk = 0;
  int             n_err = 0;

  readout_scheduler_if bus();

  readout_scheduler #(
    .PIXELS(P), .COUNTER_BITS(CB), .IDX_BITS(8), .FCNT_BITS(FCB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .sel_idx(sel_idx), .sel_field(sel_field), .data_in(data_in),
    .out(bus), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // result mux model: one cycle from select to data
  always @(posedge clk)
    data_in <= dead ? 32'hDEADBEEF : {16'h0, sel_idx, 6'h0, sel_field};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int ch, r, f, b;
    logic [31:0] w;
    ch = k / CHB;
    r  = k % CHB;
    if (r == 0) return 8'(ch);
    f = (r - 1) / NB;
    b = (r - 1) % NB;
    w = dead ? 32'hDEADBEEF : {16'h0, 8'(ch), 6'h0, 2'(f)};
    return w[31 - 8*b -: 8];
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consume one frame starting on its header cycle; stops on frame_done.
  task automatic collect(input bit bp, input int drop_at, output int cyc);
    int n = 0, bad = 0, stall_bad = 0, busy_low = 0;
    bit stalled = 1'b0;
    logic [9:0] held = '0;
    cyc = 0;
    while (!(frame_done && cyc > 0) && cyc < 2000) begin
      if (cyc == drop_at) cont = 1'b0;
      bus.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && (!bus.valid || {bus.data, bus.sof, bus.eof} !== held)) stall_bad++;
      stalled = bus.valid && !bus.ready;
      held    = {bus.data, bus.sof, bus.eof};
      if (!busy) busy_low++;
      if (bus.valid && bus.ready) begin
        if (n >= FB || bus.data !== exp_byte(n) || bus.sof !== (n == 0) ||
            bus.eof !== (n == FB - 1))
          bad++;
        else if (n % CHB != 0 &&
                 (sel_idx !== 8'(n / CHB) || sel_field !== 2'((n % CHB - 1) / NB)))
          bad++;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("frame_timeout", 32'(cyc < 2000), 1);
    chk("byte_count", n, FB);
    chk("byte_errs", bad, 0);
    chk("stall_errs", stall_bad, 0);
    chk("busy_low_in_frame", busy_low, 0);
    exp_fcnt++;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
  endtask

  initial begin
    int cyc;
    bus.ready = 1'b0;
    #2;
    chk("reset_outputs", {sel_idx, sel_field, bus.data, bus.valid, bus.sof, bus.eof,
                          busy, frame_done, frame_cnt}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // single frame, no backpressure
    start_pulse();
    chk("hdr_first", {bus.valid, bus.sof, bus.data}, {2'b11, 8'h00});
    chk("busy_start", busy, 1);
    collect(1'b0, -1, cyc);
    chk("frame_cycles", cyc, 2 * P * 19);
    chk("done_pulse", frame_done, 1);
    chk("idle_after", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", frame_done, 0);

    // same frame under random backpressure
    start_pulse();
    collect(1'b1, -1, cyc);
    chk("bp_idle_after", busy, 0);
    @(posedge clk); #1;

    // constant word: each field reads DE AD BE EF
    dead = 1'b1;
    start_pulse();
    collect(1'b0, -1, cyc);
    dead = 1'b0;
    @(posedge clk); #1;

    // continuous: three back-to-back frames, start ignored while busy
    cont = 1'b1;
    start_pulse();
    collect(1'b0, -1, cyc);
    chk("cont_busy1", busy, 1);
    chk("cont_nogap1", {bus.valid, bus.sof, bus.data}, {2'b11, 8'h00});
    start = 1'b1;
    collect(1'b0, -1, cyc);
    start = 1'b0;
    chk("cont_nogap2", {busy, bus.valid, bus.sof, bus.data}, {3'b111, 8'h00});
    collect(1'b0, 30, cyc);
    chk("cont_cycles3", cyc, 2 * P * 19);
    chk("cont_idle", {busy, bus.valid}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("stay_idle", busy, 0);

    // async reset in the middle of a SEND
    start_pulse();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midframe_reset", {sel_idx, sel_field, bus.data, bus.valid, bus.sof, bus.eof,
                           busy, frame_done, frame_cnt}, 0);
    #3 rst_n = 1'b1;
    exp_fcnt = '0;
    @(posedge clk); #1;
    chk("reset_stays_idle", busy, 0);
    start_pulse();
    chk("hdr_after_reset", {busy, bus.valid, bus.sof, bus.data}, {3'b111, 8'h00});
    collect(1'b0, -1, cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/readout_scheduler.md
Name: readout_scheduler

Overview:
- Sequences readout of the per-pixel frequency counter results (TIME_HIGH, TIME_LOW, PERIOD) for all row and column channels.
- Serializes each result onto an 8-bit byte stream with a valid/ready handshake, feeding the chip output pins.
- Drives the channel/field select of an external result mux, captures the 32-bit word, then emits a header byte plus MSB-first data bytes per channel.
- Runs single-shot or continuous frames.

Parameters:
- PIXELS, 128, pixels per axis; channels 0..PIXELS-1 are rows, PIXELS..2*PIXELS-1 are columns.
- COUNTER_BITS, 32, width of each counter result; must be a multiple of 8.
- IDX_BITS, 8, width of the channel index; must satisfy 2^IDX_BITS >= 2*PIXELS.
- FCNT_BITS, 16, width of the completed-frame counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  begin a frame; sampled only in IDLE.
- CONT  input  1  continuous mode; sampled at end of each frame.
- SEL_IDX  output  IDX_BITS  channel select to the result mux.
- SEL_FIELD  output  2  field select: 0=TIME_HIGH, 1=TIME_LOW, 2=PERIOD.
- DATA_IN  input  COUNTER_BITS  mux result; valid one cycle after SEL_* change.
- OUT_DATA  output  8  stream byte.
- OUT_VALID  output  1  OUT_DATA valid.
- OUT_READY  input  1  consumer accepts the byte.
- OUT_SOF  output  1  qualifies the header byte of channel 0.
- OUT_EOF  output  1  qualifies the last byte of the last channel.
- BUSY  output  1  high whenever not IDLE.
- FRAME_DONE  output  1  one-cycle pulse after the final handshake of a frame.
- FRAME_CNT  output  FCNT_BITS  completed frames; wraps modulo 2^FCNT_BITS.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; all outputs 0 (SEL_IDX, SEL_FIELD, OUT_DATA, OUT_VALID, OUT_SOF, OUT_EOF, BUSY, FRAME_DONE, FRAME_CNT); internal word, idx, field and byte counters cleared. Reset mid-frame abandons the frame with no partial EOF.
- Handshake: a byte transfers on a cycle with OUT_VALID & OUT_READY. While OUT_VALID=1 and OUT_READY=0, OUT_DATA/OUT_SOF/OUT_EOF hold stable and OUT_VALID stays high. OUT_VALID never depends combinationally on OUT_READY.
- SEL_IDX/SEL_FIELD are registered and held constant from SEL through all SEND cycles of that field.
- FSM states:
  - IDLE: BUSY=0. START=1 → idx=0, field=0, go HDR. START in any other state is ignored.
  - HDR: OUT_VALID=1, OUT_DATA=idx[7:0], OUT_SOF=(idx==0). On handshake → SEL.
  - SEL: drives SEL_IDX=idx, SEL_FIELD=field. One wait cycle → CAP.
  - CAP: word<=DATA_IN, byte_cnt=0 → SEND.
  - SEND: OUT_VALID=1, OUT_DATA=word byte [COUNTER_BITS-1-8*byte_cnt -: 8] (MSB first). On handshake:
    - byte_cnt < COUNTER_BITS/8-1 → byte_cnt++.
    - Else if field<2 → field++, go SEL.
    - Else if idx<2*PIXELS-1 → idx++, field=0, go HDR.
    - Else the frame ends: FRAME_DONE=1 next cycle, FRAME_CNT++. Then CONT=1 → idx=0, go HDR (no IDLE cycle; BUSY stays 1); CONT=0 → IDLE.
- OUT_EOF=1 only in SEND with idx=2*PIXELS-1, field=2, last byte.
- Frame length: 2*PIXELS*(1+3*COUNTER_BITS/8) bytes; 3328 at defaults.
- Latency (OUT_READY=1): START at cycle t → header OUT_VALID at t+1. Each channel takes 1+3*(2+COUNTER_BITS/8) cycles; 19 at defaults.
- CONT deasserted mid-frame: current frame completes, then IDLE.
- FRAME_CNT at all-ones wraps to 0.

Test Plan:
- PIXELS=2, OUT_READY=1, DATA_IN = {idx, field} encoded as 0x0000_0Ixx with I=idx, low byte=field; pulse START → 52 bytes in 76 cycles. Ch0 begins 0x00(SOF), 0x00,0x00,0x00,0x00, …, 0x00,0x00,0x01,0x02 … EOF on byte 52; FRAME_DONE one pulse; FRAME_CNT=1; BUSY back to 0.
- Backpressure: OUT_READY toggled pseudo-randomly → byte sequence identical to the previous case; OUT_DATA stable on every stalled cycle.
- Select timing: check SEL_IDX/SEL_FIELD are stable for ≥1 cycle before CAP, and the captured word equals DATA_IN at the CAP cycle. Drive DATA_IN=0xDEADBEEF → bytes DE AD BE EF.
- CONT=1 for 3 frames, then dropped mid-frame 3 → frames back-to-back with no IDLE gap; FRAME_CNT=3; IDLE after frame 3; START during BUSY ignored.
- RST_N asserted mid-SEND (asynchronous, between edges) → all outputs 0 immediately. A new START gives a header of 0x00 with SOF.
- FCNT_BITS=2, CONT=1 → FRAME_CNT sequence 1,2,3,0.
